// File: rtl/ic_dma_pkg.sv
// rtl/ic_dma_pkg.sv - shared widths, state encoding and address helper for the I-cache line-fill DMA
//
// Purpose : common definitions imported by ic_line_packer and ic_dma_responder.
// Ports   : none (package).
package ic_dma_pkg;

    localparam int ADDR_W        = 33;
    localparam int LINE_W        = 128;
    localparam int WORD_W        = 32;
    // A 128-bit line spans 16 bytes, so the low 4 address bits are the in-line offset.
    localparam int LINE_OFFSET_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        COLLECT = 3'd2,
        ACK     = 3'd3,
        GAP     = 3'd4
    } dma_state_t;

    // Clears the in-line byte offset; all upper bits pass through untouched.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << LINE_OFFSET_W) - 1);
    endfunction

endpackage

// File: rtl/ic_line_packer.sv
// rtl/ic_line_packer.sv - beat counter and word-insert register that assembles one cache line
//
// Purpose : collects BEATS 32-bit memory words into a 128-bit line, beat k landing in
//           bits [32*k+31:32*k].
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_clr         - clear counter and line (start of a new request)
//           i_wr_en       - accept i_wr_data as the next beat
//           i_wr_data     - memory data beat
//           o_last        - the beat being accepted now completes the line
//           o_line_next   - line contents including the beat accepted this cycle
module ic_line_packer
    import ic_dma_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic              o_last,
    output logic [LINE_W-1:0] o_line_next
);

    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  r_count;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] w_line_next;

    // The merged view lets the owner capture a complete line on the same edge
    // that writes the final beat.
    always_comb begin
        w_line_next = r_line;
        if (i_wr_en) begin
            w_line_next[int'(r_count) * WORD_W +: WORD_W] = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
            r_line  <= '0;
        end else if (i_wr_en) begin
            r_count <= r_count + CNT_W'(1);
            r_line  <= w_line_next;
        end
    end

    assign o_last      = i_wr_en && (r_count == LAST_BEAT);
    assign o_line_next = w_line_next;

endmodule

// File: rtl/ic_dma_responder.sv
// rtl/ic_dma_responder.sv - I-cache line-fill responder: one burst read of four beats per request
//
// Purpose : accepts a line-fill request from the I-cache, issues a line-aligned burst read,
//           assembles four 32-bit beats into a 128-bit line and returns it with a one-cycle
//           ack. A stalled grant or beat stream aborts the burst with err=1 and data=0.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           ic_read_dma_valid   - request from the I-cache, held until ack
//           ic_read_dma_addr    - byte address of the wanted line
//           ic_read_dma_ack     - one-cycle completion pulse
//           ic_read_dma_data    - assembled line, held from one ack to the next
//           ic_read_dma_err     - with ack, the burst timed out
//           mem_rd_req          - burst read request to memory
//           mem_rd_addr         - line-aligned burst base address
//           mem_rd_gnt          - memory accepted the request
//           mem_rd_dvalid       - memory data beat valid
//           mem_rd_data         - memory data beat
module ic_dma_responder
    import ic_dma_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int BEATS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read_dma_valid,
    input  logic [ADDR_W-1:0] ic_read_dma_addr,
    output logic              ic_read_dma_ack,
    output logic [LINE_W-1:0] ic_read_dma_data,
    output logic              ic_read_dma_err,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_dvalid,
    input  logic [WORD_W-1:0] mem_rd_data
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    // The counter reads 0 in the first cycle after an event, so deciding at
    // TIMEOUT-2 places the error ack exactly TIMEOUT cycles after the last
    // grant/beat (or after the first ISSUE cycle's predecessor). TIMEOUT >= 2.
    localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT - 2);

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic              r_ack;
    logic              r_err;
    logic [LINE_W-1:0] r_data;

    logic              w_accept;
    logic              w_gnt_evt;
    logic              w_beat;
    logic              w_event;
    logic              w_timeout;
    logic              w_last;
    logic              w_busy;
    logic [LINE_W-1:0] w_line_next;

    assign w_accept  = (r_state == IDLE) && ic_read_dma_valid;
    assign w_gnt_evt = (r_state == ISSUE) && mem_rd_gnt;
    assign w_busy    = (r_state == ISSUE) || (r_state == COLLECT);
    // A beat arriving together with the grant is the first beat; beats in any
    // other state are stray and dropped.
    assign w_beat    = mem_rd_dvalid && ((r_state == COLLECT) || w_gnt_evt);
    assign w_event   = w_gnt_evt || w_beat;
    assign w_timeout = w_busy && !w_event && (r_tmo == TMO_FIRE);

    ic_line_packer #(
        .BEATS (BEATS)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_wr_en     (w_beat),
        .i_wr_data   (mem_rd_data),
        .o_last      (w_last),
        .o_line_next (w_line_next)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (ic_read_dma_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_last || w_timeout) begin
                    w_next = ACK;
                end else if (mem_rd_gnt) begin
                    w_next = COLLECT;
                end
            end
            COLLECT: begin
                if (w_last || w_timeout) begin
                    w_next = ACK;
                end
            end
            ACK:     w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo  <= '0;
            r_addr <= '0;
            r_req  <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else begin
            // Restart on every grant/beat; outside ISSUE/COLLECT it rests at 0,
            // which also covers the restart on entry to ISSUE.
            if (w_event || !w_busy) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_accept) begin
                r_addr <= line_align(ic_read_dma_addr);
            end

            r_req <= (w_next == ISSUE);
            r_ack <= (w_next == ACK);

            if (w_busy && (w_next == ACK)) begin
                r_err  <= w_timeout;
                r_data <= w_timeout ? '0 : w_line_next;
            end else begin
                r_err  <= 1'b0;
            end
        end
    end

    assign ic_read_dma_ack  = r_ack;
    assign ic_read_dma_data = r_data;
    assign ic_read_dma_err  = r_err;
    assign mem_rd_req       = r_req;
    assign mem_rd_addr      = r_addr;

endmodule

// File: doc/ic_dma_responder.md
IC_DMA_RESPONDER -- requirements
Module: ic_dma_responder

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles allowed between grant/beat events before the burst is aborted.
REQ-002 Parameter BEATS, default 4: 32-bit memory beats per 128-bit cache line (fixed 4; other values unsupported).
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ic_read_dma_valid  input  1  line-fill request from the I-cache FSM, held high until ack.
REQ-006 ic_read_dma_addr  input  33  byte address of the requested line.
REQ-007 ic_read_dma_ack  output  1  one-cycle completion pulse.
REQ-008 ic_read_dma_data  output  128  assembled line, valid in the ack cycle.
REQ-009 ic_read_dma_err  output  1  high with ack when the burst timed out.
REQ-010 mem_rd_req  output  1  burst read request to memory.
REQ-011 mem_rd_addr  output  33  line-aligned burst base address.
REQ-012 mem_rd_gnt  input  1  memory accepted the request.
REQ-013 mem_rd_dvalid  input  1  memory data beat valid.
REQ-014 mem_rd_data  input  32  memory data beat.

Function
REQ-015 States SHALL be IDLE, ISSUE, COLLECT, ACK, GAP.
REQ-016 IDLE: on ic_read_dma_valid=1, latch {addr[32:4],4'b0} into mem_rd_addr, clear beat counter and line register, go to ISSUE.
REQ-017 ISSUE: mem_rd_req=1 with mem_rd_addr stable; on mem_rd_gnt=1, drop req next cycle, go to COLLECT.
REQ-018 COLLECT: each mem_rd_dvalid=1 writes mem_rd_data to line bits [32*k+31:32*k], k = beat count 0..3, then increments k.
REQ-019 After beat 3 is written, go to ACK; ack SHALL assert the cycle after the 4th dvalid (latency one cycle).
REQ-020 ACK: ic_read_dma_ack=1 for exactly one cycle, ic_read_dma_data = line register, then go to GAP.
REQ-021 GAP: one cycle in which ic_read_dma_valid is ignored (requester drops valid after ack), then IDLE.
REQ-022 ic_read_dma_data SHALL hold its value from ACK until the next ACK.
REQ-023 Timeout counter SHALL reset on entry to ISSUE, on grant and on every beat; reaching TIMEOUT in ISSUE or COLLECT goes to ACK with err=1 and data=0.
REQ-024 mem_rd_dvalid outside COLLECT (stray/late beats) SHALL be ignored.
REQ-025 mem_rd_dvalid in the same cycle as mem_rd_gnt SHALL be counted as beat 0.
REQ-026 Dropping ic_read_dma_valid mid-burst SHALL NOT abort the burst; ack still issues.
REQ-027 Address bits [3:0] SHALL be ignored; the 33-bit address SHALL pass unmodified otherwise (no wrap arithmetic).

Reset
REQ-028 rst=1 SHALL force state IDLE, and ack, err, mem_rd_req, mem_rd_addr, ic_read_dma_data, beat and timeout counters to 0.
REQ-029 rst mid-burst SHALL discard collected beats; no ack SHALL be issued for the aborted request.

Structure
REQ-030 Shared package ic_dma_pkg SHALL hold ADDR_W=33, LINE_W=128, WORD_W=32 and the state encoding.
REQ-031 One sub-module ic_line_packer (beat counter plus 4x32 shift/insert register) is natural; FSM and timeout stay in the top.

Verification
REQ-032 Valid, addr=0x0_0000_0010; gnt after 2 cycles; beats 0x11,0x22,0x33,0x44 back-to-back -> mem_rd_addr=0x10, ack one cycle after 4th beat, data=0x00000044_00000033_00000022_00000011, err=0.
REQ-033 addr=0x0_0000_001C -> mem_rd_addr=0x10 (low nibble cleared).
REQ-034 Beats with 3 idle cycles between each -> same data, ack exactly one pulse, counter restarts per beat.
REQ-035 Grant given, no beats, TIMEOUT=8 -> ack with err=1, data=0, 8 cycles after grant.
REQ-036 rst pulsed after beat 1, then a stray dvalid in IDLE -> no ack, all outputs 0, next request completes normally.
REQ-037 Valid held high through ack and GAP -> second burst starts only on the IDLE cycle after GAP.
